// File: rtl/udp_tx_sched.sv
// udp_tx_sched: packet-granular round-robin scheduler sharing the UDP/IP tx
// payload path between N_REQ application streams.
//
// The grant is held by one requester from its first beat through its last
// beat, then a one-cycle GAP enforces the inter-payload gap. A watchdog aborts
// a packet whose owner (or the downstream) stops moving beats for TIMEOUT cycles.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   req_valid_i    per-requester beat valid
//   req_data_i     per-requester data, requester k at [k*DATA_W +: DATA_W]
//   req_len_i      per-requester byte count, requester k at [k*LEN_W +: LEN_W]
//   req_last_i     per-requester last beat of packet
//   req_ready_o    beat taken from requester k when valid & ready
//   req_abort_o    one-cycle pulse: requester k's packet was aborted
//   valid_o, data_o, len_o, last_o, ready_i   beat stream to UDP tx
//   cancel_o       one-cycle pulse: discard packet in progress
//   busy_o         scheduler not idle
//
// state | meaning
// IDLE  | arbitrate among valid requesters, no beat accepted
// XFER  | grant locked to sel, beats forwarded, watchdog running
// GAP   | one dead cycle after a packet ends or is aborted

module udp_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = $clog2(DATA_W/8),
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*LEN_W-1:0]  req_len_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        req_abort_o,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic                    cancel_o,
  output logic                    busy_o
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    XFER = 3'b010,
    GAP  = 3'b100
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] arb_idx;
  logic [SEL_W-1:0] cand;
  logic             arb_found;
  logic [TO_W-1:0]  wdog;
  logic             beat_acc;
  logic             wd_expire;

  // Scan downward in offset so the requester closest to rr_ptr is the last
  // (and therefore winning) assignment.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      cand = SEL_W'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid_i[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    len_o       = '0;
    last_o      = 1'b0;
    req_ready_o = '0;
    if (state == XFER) begin
      valid_o          = req_valid_i[sel];
      data_o           = req_data_i[sel*DATA_W +: DATA_W];
      len_o            = req_len_i[sel*LEN_W +: LEN_W];
      last_o           = req_last_i[sel] & req_valid_i[sel];
      req_ready_o[sel] = ready_i;
    end
  end

  assign sel_inc   = (sel == SEL_W'(N_REQ-1)) ? '0 : sel + 1'b1;
  assign beat_acc  = valid_o & ready_i;
  // An accepted beat on the terminal cycle takes priority over the abort.
  assign wd_expire = (state == XFER) && !beat_acc && (wdog == TO_W'(TIMEOUT-1));
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      wdog        <= '0;
      cancel_o    <= 1'b0;
      req_abort_o <= '0;
    end else begin
      cancel_o    <= 1'b0;
      req_abort_o <= '0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (arb_found) begin
            sel   <= arb_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (beat_acc) begin
            wdog <= '0;
            if (last_o) begin
              state  <= GAP;
              rr_ptr <= sel_inc;
            end
          end else if (wd_expire) begin
            wdog             <= '0;
            cancel_o         <= 1'b1;
            req_abort_o[sel] <= 1'b1;
            state            <= GAP;
            rr_ptr           <= sel_inc;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        GAP: begin
          wdog  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot(state));
      assert ($onehot0(req_ready_o));
      assert (!(cancel_o && valid_o));
      assert (!$isunknown({valid_o, cancel_o, last_o}));
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
module tb_udp_tx_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [63:0] req_data_i;
  logic [3:0]  req_len_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  req_abort_o;
  logic        valid_o;
  logic [15:0] data_o;
  logic [0:0]  len_o;
  logic        last_o;
  logic        ready_i;
  logic        cancel_o;
  logic        busy_o;

  udp_tx_sched dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_len_i(req_len_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .req_abort_o(req_abort_o),
    .valid_o(valid_o), .data_o(data_o), .len_o(len_o), .last_o(last_o),
    .ready_i(ready_i), .cancel_o(cancel_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic        tv[4];
  logic [15:0] td[4];
  logic        tl[4];
  logic        tlast[4];
  bit          kill[4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_valid_i[k]          = tv[k];
      req_data_i[k*16 +: 16]  = td[k];
      req_len_i[k]            = tl[k];
      req_last_i[k]           = tlast[k];
    end
  end

  typedef struct {
    int          src;
    logic [15:0] data;
    logic        len;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_cancel[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    checks++;
    failures++;
    $display("FAIL %s %s", nm, msg);
  endtask

  task automatic push_beat(input int k, input logic [15:0] d, input logic l, input logic lst);
    beat_t e;
    e.src = k; e.data = d; e.len = l; e.last = lst;
    exp_q.push_back(e);
  endtask

  // Beat b of a packet carries base*(b+1), len = b[0], last on final beat.
  task automatic push_pkt(input int k, input int n, input logic [15:0] base);
    for (int b = 0; b < n; b++)
      push_beat(k, 16'(base * (b+1)), b[0], (b == n-1));
  endtask

  // Called on a falling edge. gap = idle cycles between beats; stub = send
  // the first beat (not last) and then go silent.
  task automatic send_pkt(input int k, input int n, input logic [15:0] base,
                          input int gap, input bit stub);
    int b = 0;
    int budget = 0;
    int nb = stub ? 1 : n;
    while (b < nb && !kill[k]) begin
      tv[k] = 1'b1;
      td[k] = 16'(base * (b+1));
      tl[k] = b[0];
      tlast[k] = !stub && (b == n-1);
      #1;
      if (kill[k]) break;
      if (req_ready_o[k]) begin
        b++;
        budget = 0;
        @(negedge clk);
        if (b < nb && gap > 0) begin
          tv[k] = 1'b0;
          tlast[k] = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end else begin
        budget++;
        if (budget > 200) begin
          fail_now("drv_timeout", $sformatf("req=%0d actual=stalled required=accepted", k));
          break;
        end
        @(negedge clk);
      end
    end
    tv[k] = 1'b0;
    tlast[k] = 1'b0;
  endtask

  // Scoreboard monitor: samples 2 time units after each falling edge.
  initial begin : monitor
    beat_t e;
    int    src;
    bit    prev_v;
    int    cyc;
    int    last_end;
    prev_v = 1'b0;
    cyc = 0;
    last_end = -100;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset) begin
        prev_v = 1'b0;
        continue;
      end
      if (valid_o && !prev_v)
        chk("pkt_spacing_ok", 32'(cyc - last_end >= 3), 32'd1);
      if (valid_o && exp_q.size() > 0)
        chk("ready_vec", 32'(req_ready_o), ready_i ? (32'd1 << exp_q[0].src) : 32'd0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat", $sformatf("actual=0x%0h required=none", data_o));
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(data_o), 32'(e.data));
          chk("beat_len", 32'(len_o), 32'(e.len));
          chk("beat_last", 32'(last_o), 32'(e.last));
          if (last_o) last_end = cyc;
        end
      end
      if (cancel_o) begin
        chk("cancel_vs_valid", 32'(valid_o), 32'd0);
        if (exp_cancel.size() == 0) begin
          fail_now("unexpected_cancel", $sformatf("actual=abort 0x%0h required=no cancel", req_abort_o));
        end else begin
          src = exp_cancel.pop_front();
          chk("abort_vec", 32'(req_abort_o), 32'd1 << src);
        end
      end else if (req_abort_o != 4'b0) begin
        fail_now("abort_without_cancel", $sformatf("actual=0x%0h required=0", req_abort_o));
      end
      prev_v = valid_o;
    end
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int k = 0; k < 4; k++) begin
      tv[k] = 1'b0; td[k] = '0; tl[k] = 1'b0; tlast[k] = 1'b0; kill[k] = 1'b0;
    end
    reset = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_outs", 32'({req_ready_o, req_abort_o, last_o, cancel_o, busy_o}), 0);
    chk("rst_data_len", 32'({data_o, len_o}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single requester, 3 beats; no beat in the arbitration cycle.
    push_pkt(0, 3, 16'h1111);
    fork
      send_pkt(0, 3, 16'h1111, 0, 0);
      begin
        #2;
        chk("idle_no_ready", 32'(req_ready_o), 0);
        chk("idle_busy", 32'(busy_o), 0);
        @(negedge clk);
        #2;
        chk("xfer_busy", 32'(busy_o), 1);
        chk("xfer_grant0", 32'(req_ready_o), 32'h1);
      end
    join
    #1;
    chk("gap_busy", 32'(busy_o), 1);
    chk("gap_quiet", 32'({valid_o, req_ready_o}), 0);
    @(negedge clk);
    #1;
    chk("after_gap_idle", 32'(busy_o), 0);
    repeat (2) @(negedge clk);

    // Reset clears the pointer (was 1): req0 must win over req2.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_pkt(0, 2, 16'h0A0A);
    push_pkt(2, 2, 16'h0C0C);
    fork
      send_pkt(0, 2, 16'h0A0A, 0, 0);
      send_pkt(2, 2, 16'h0C0C, 0, 0);
    join
    repeat (3) @(negedge clk);

    // Pointer 3: req3 first, then wrap to req0.
    push_pkt(3, 2, 16'h0303);
    push_pkt(0, 2, 16'h0B0B);
    fork
      send_pkt(3, 2, 16'h0303, 0, 0);
      send_pkt(0, 2, 16'h0B0B, 0, 0);
    join
    repeat (3) @(negedge clk);

    // Downstream stall of 5 cycles mid-packet, well under the timeout.
    push_pkt(1, 4, 16'h0101);
    fork
      send_pkt(1, 4, 16'h0101, 0, 0);
      begin
        repeat (2) @(negedge clk);
        ready_i = 1'b0;
        repeat (5) @(negedge clk);
        ready_i = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    // Owner goes silent after one beat: abort after 16 stalled cycles.
    push_beat(1, 16'h5151, 1'b0, 1'b0);
    exp_cancel.push_back(1);
    send_pkt(1, 1, 16'h5151, 0, 1);
    repeat (15) @(negedge clk);
    #1;
    chk("wd_no_early_cancel", 32'(cancel_o), 0);
    chk("wd_still_busy", 32'(busy_o), 1);
    @(negedge clk);
    #1;
    chk("wd_cancel", 32'(cancel_o), 1);
    chk("wd_abort1", 32'(req_abort_o), 32'h2);
    chk("wd_no_valid", 32'(valid_o), 0);
    @(negedge clk);
    #1;
    chk("wd_cancel_pulse", 32'({cancel_o, req_abort_o}), 0);
    chk("wd_idle", 32'(busy_o), 0);
    @(negedge clk);

    // Pointer advanced past the aborted req1: req2 before req1.
    push_pkt(2, 1, 16'h2222);
    push_pkt(1, 1, 16'h1212);
    fork
      send_pkt(2, 1, 16'h2222, 0, 0);
      send_pkt(1, 1, 16'h1212, 0, 0);
    join
    repeat (3) @(negedge clk);

    // Beats land exactly on the terminal watchdog cycle: no abort.
    push_pkt(3, 3, 16'h0707);
    send_pkt(3, 3, 16'h0707, 15, 0);
    repeat (3) @(negedge clk);

    // Reset during beat 2 of a 4-beat packet: dropped silently.
    push_beat(0, 16'h4444, 1'b0, 1'b0);
    fork
      send_pkt(0, 4, 16'h4444, 0, 0);
      begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        kill[0] = 1'b1;
      end
    join
    @(negedge clk);
    #1;
    chk("midrst_outs", 32'({valid_o, last_o, cancel_o, busy_o, req_ready_o, req_abort_o}), 0);
    chk("midrst_data", 32'({data_o, len_o}), 0);
    reset = 1'b0;
    kill[0] = 1'b0;
    @(negedge clk);
    push_pkt(0, 2, 16'h0909);
    send_pkt(0, 2, 16'h0909, 0, 0);
    repeat (5) @(negedge clk);

    chk("beats_outstanding", 32'(exp_q.size()), 0);
    chk("cancels_outstanding", 32'(exp_cancel.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
